// File: rtl/apb_protocol_checker.sv
// Passive APB port monitor: flags handshake/timing violations as pulses and sticky bits,
// and keeps saturating transfer, slave-error and worst-case wait statistics.
module apb_protocol_checker #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
    output logic [5:0]        viol_pulse,
    output logic [5:0]        viol_sticky,
    output logic              xfer_done,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  max_wait_seen,
    output logic [1:0]        dbg_phase
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic             TIMEOUT_EN = (MAX_WAIT != 0);

    phase_t              r_phase;
    phase_t              w_phase;
    logic [ADDR_W-1:0]   r_prev_paddr;
    logic [DATA_W-1:0]   r_prev_pwdata;
    logic                r_prev_pwrite;
    logic                r_prev_psel;
    logic                r_prev_penable;
    logic                r_prev_pready;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_timeout_flag;

    logic                w_access;
    logic                w_stall;
    logic                w_done;
    logic                w_prev_access;
    logic                w_bus_changed;
    logic [5:0]          w_viol;
    logic [CNT_W-1:0]    w_xfer_base;
    logic [CNT_W-1:0]    w_err_base;
    logic [CNT_W-1:0]    w_maxw_base;
    logic [CNT_W-1:0]    w_xfer_next;
    logic [CNT_W-1:0]    w_err_next;
    logic [CNT_W-1:0]    w_maxw_next;
    logic [CNT_W-1:0]    w_wait_next;
    logic                w_timeout_next;
    logic                w_unused_prdata;

    // Read data carries no protocol obligation that this monitor checks.
    assign w_unused_prdata = ^prdata;
    assign dbg_phase       = r_phase;

    // Phase of the cycle currently on the bus, decoded from psel/penable alone.
    always_comb begin
        w_phase = PH_IDLE;
        if (psel && penable) begin
            w_phase = PH_ACCESS;
        end else if (psel) begin
            w_phase = PH_SETUP;
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_phase <= PH_IDLE;
        end else begin
            r_phase <= w_phase;
        end
    end

    always_comb begin
        w_access      = (w_phase == PH_ACCESS);
        w_stall       = w_access & ~pready;
        w_done        = w_access & pready;
        w_prev_access = (r_phase == PH_ACCESS);
        w_bus_changed = (paddr != r_prev_paddr) | (pwrite != r_prev_pwrite) |
                        (pwdata != r_prev_pwdata) | (psel != r_prev_psel) |
                        (penable != r_prev_penable);

        w_viol    = '0;
        w_viol[0] = penable & ~psel;
        w_viol[1] = penable & ~r_prev_penable & (r_phase != PH_SETUP);
        // A wait cycle obliges the master to hold the whole request into the next cycle.
        w_viol[2] = w_prev_access & ~r_prev_pready & w_bus_changed;
        w_viol[3] = pslverr & ~w_access;
        w_viol[4] = w_prev_access & r_prev_pready & penable;
        w_viol[5] = TIMEOUT_EN & w_stall & (r_wait_cnt == MAX_WAIT_C) & ~r_timeout_flag;

        // clr wipes the history first so an event on the same edge still lands.
        w_xfer_base = clr ? '0 : xfer_cnt;
        w_err_base  = clr ? '0 : err_cnt;
        w_maxw_base = clr ? '0 : max_wait_seen;

        w_xfer_next = w_xfer_base;
        if (w_done && (w_xfer_base != CNT_MAX)) begin
            w_xfer_next = w_xfer_base + CNT_ONE;
        end
        w_err_next = w_err_base;
        if (w_done && pslverr && (w_err_base != CNT_MAX)) begin
            w_err_next = w_err_base + CNT_ONE;
        end
        w_maxw_next = w_maxw_base;
        if (w_done && (r_wait_cnt > w_maxw_base)) begin
            w_maxw_next = r_wait_cnt;
        end

        w_wait_next    = '0;
        w_timeout_next = 1'b0;
        if (w_stall) begin
            w_wait_next    = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_ONE;
            w_timeout_next = r_timeout_flag | w_viol[5];
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_prev_paddr   <= '0;
            r_prev_pwdata  <= '0;
            r_prev_pwrite  <= 1'b0;
            r_prev_psel    <= 1'b0;
            r_prev_penable <= 1'b0;
            r_prev_pready  <= 1'b0;
            r_wait_cnt     <= '0;
            r_timeout_flag <= 1'b0;
            viol_pulse     <= '0;
            viol_sticky    <= '0;
            xfer_done      <= 1'b0;
            xfer_cnt       <= '0;
            err_cnt        <= '0;
            max_wait_seen  <= '0;
        end else begin
            r_prev_paddr   <= paddr;
            r_prev_pwdata  <= pwdata;
            r_prev_pwrite  <= pwrite;
            r_prev_psel    <= psel;
            r_prev_penable <= penable;
            r_prev_pready  <= pready;
            r_wait_cnt     <= w_wait_next;
            r_timeout_flag <= w_timeout_next;
            viol_pulse     <= w_viol;
            viol_sticky    <= (clr ? 6'b0 : viol_sticky) | w_viol;
            xfer_done      <= w_done;
            xfer_cnt       <= w_xfer_next;
            err_cnt        <= w_err_next;
            max_wait_seen  <= w_maxw_next;
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Bench for apb_protocol_checker: directed vector table, hand-written corner sequences,
// and randomized bus traffic scored against a cycle-level rule model.
module tb_apb_protocol_checker;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;
    localparam int SAT      = 65535;

    logic              pclk;
    logic              prst;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              clr;
    logic [5:0]        viol_pulse;
    logic [5:0]        viol_sticky;
    logic              xfer_done;
    logic [CNT_W-1:0]  xfer_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  max_wait_seen;
    logic [1:0]        dbg_phase;

    apb_protocol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .clr(clr), .viol_pulse(viol_pulse),
        .viol_sticky(viol_sticky), .xfer_done(xfer_done), .xfer_cnt(xfer_cnt),
        .err_cnt(err_cnt), .max_wait_seen(max_wait_seen), .dbg_phase(dbg_phase)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       psel;
        logic       penable;
        logic       pwrite;
        logic [7:0] paddr;
        logic [7:0] pwdata;
        logic       pready;
        logic       pslverr;
        logic       clr;
    } bus_t;

    typedef struct {
        bus_t        b;
        logic [5:0]  pulse;
        logic [5:0]  sticky;
        logic        done;
        logic [15:0] xfer;
        logic [15:0] err;
        logic [15:0] maxw;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bus_t       m_prev;
    int         m_wait;
    bit         m_tflag;
    logic [5:0] m_pulse;
    logic [5:0] m_sticky;
    logic       m_done;
    int         m_xfer;
    int         m_err;
    int         m_maxw;

    function automatic bus_t mkb(input logic sel, input logic en, input logic wr,
                                 input logic [7:0] a, input logic [7:0] d,
                                 input logic rdy, input logic serr, input logic c);
        bus_t r;
        r.psel = sel; r.penable = en; r.pwrite = wr; r.paddr = a; r.pwdata = d;
        r.pready = rdy; r.pslverr = serr; r.clr = c;
        return r;
    endfunction

    function automatic vec_t mkv(input bus_t b, input logic [5:0] p, input logic [5:0] s,
                                 input logic d, input logic [15:0] x, input logic [15:0] e,
                                 input logic [15:0] m);
        vec_t v;
        v.b = b; v.pulse = p; v.sticky = s; v.done = d; v.xfer = x; v.err = e; v.maxw = m;
        return v;
    endfunction

    task automatic model_reset();
        m_prev   = mkb(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        m_wait   = 0;
        m_tflag  = 0;
        m_pulse  = '0;
        m_sticky = '0;
        m_done   = 0;
        m_xfer   = 0;
        m_err    = 0;
        m_maxw   = 0;
    endtask

    task automatic model_step(input bus_t b);
        bit         cur_acc, prev_acc, prev_setup, stall, done, chg;
        logic [5:0] v;
        int         base;
        cur_acc    = b.psel && b.penable;
        prev_acc   = m_prev.psel && m_prev.penable;
        prev_setup = m_prev.psel && !m_prev.penable;
        stall      = cur_acc && !b.pready;
        done       = cur_acc && b.pready;
        chg = (b.paddr != m_prev.paddr) || (b.pwrite != m_prev.pwrite) ||
              (b.pwdata != m_prev.pwdata) || (b.psel != m_prev.psel) ||
              (b.penable != m_prev.penable);
        v    = '0;
        v[0] = b.penable && !b.psel;
        v[1] = b.penable && !m_prev.penable && !prev_setup;
        v[2] = prev_acc && !m_prev.pready && chg;
        v[3] = b.pslverr && !cur_acc;
        v[4] = prev_acc && m_prev.pready && b.penable;
        v[5] = (MAX_WAIT != 0) && stall && (m_wait == MAX_WAIT) && !m_tflag;
        m_pulse  = v;
        m_sticky = (b.clr ? 6'b0 : m_sticky) | v;
        m_done   = done;
        base   = b.clr ? 0 : m_xfer;
        m_xfer = done ? ((base + 1 > SAT) ? SAT : base + 1) : base;
        base   = b.clr ? 0 : m_err;
        m_err  = (done && b.pslverr) ? ((base + 1 > SAT) ? SAT : base + 1) : base;
        base   = b.clr ? 0 : m_maxw;
        m_maxw = (done && m_wait > base) ? m_wait : base;
        m_tflag = stall ? (m_tflag || v[5]) : 0;
        m_wait  = stall ? ((m_wait + 1 > SAT) ? SAT : m_wait + 1) : 0;
        m_prev  = b;
    endtask

    // ---------------- driver ----------------
    task automatic apply(input bus_t b);
        psel    = b.psel;
        penable = b.penable;
        pwrite  = b.pwrite;
        paddr   = b.paddr;
        pwdata  = b.pwdata;
        pready  = b.pready;
        pslverr = b.pslverr;
        clr     = b.clr;
        prdata  = 8'($urandom);
        model_step(b);
        @(posedge pclk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_bundle();
        return {3'b0, viol_pulse, viol_sticky, xfer_done, xfer_cnt, err_cnt, max_wait_seen};
    endfunction

    function automatic logic [63:0] model_bundle();
        return {3'b0, m_pulse, m_sticky, m_done, 16'(m_xfer), 16'(m_err), 16'(m_maxw)};
    endfunction

    vec_t vecs[18];
    bus_t last;
    bus_t cur;
    bus_t idle_b;
    bus_t burst_b;
    bit   legal_pen;

    initial begin
        idle_b = mkb(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[0]  = mkv(idle_b,                                   6'b000000, 6'b000000, 0, 0, 0, 0);
        vecs[1]  = mkv(mkb(1, 0, 1, 8'h3C, 8'hA5, 0, 0, 0),      6'b000000, 6'b000000, 0, 0, 0, 0);
        vecs[2]  = mkv(mkb(1, 1, 1, 8'h3C, 8'hA5, 1, 0, 0),      6'b000000, 6'b000000, 1, 1, 0, 0);
        vecs[3]  = mkv(idle_b,                                   6'b000000, 6'b000000, 0, 1, 0, 0);
        vecs[4]  = mkv(mkb(1, 0, 0, 8'h20, 8'h00, 0, 0, 0),      6'b000000, 6'b000000, 0, 1, 0, 0);
        vecs[5]  = mkv(mkb(1, 1, 0, 8'h20, 8'h00, 0, 0, 0),      6'b000000, 6'b000000, 0, 1, 0, 0);
        vecs[6]  = mkv(mkb(1, 1, 0, 8'h20, 8'h00, 0, 0, 0),      6'b000000, 6'b000000, 0, 1, 0, 0);
        vecs[7]  = mkv(mkb(1, 1, 0, 8'h20, 8'h00, 0, 0, 0),      6'b000000, 6'b000000, 0, 1, 0, 0);
        vecs[8]  = mkv(mkb(1, 1, 0, 8'h20, 8'h00, 1, 1, 0),      6'b000000, 6'b000000, 1, 2, 1, 3);
        vecs[9]  = mkv(idle_b,                                   6'b000000, 6'b000000, 0, 2, 1, 3);
        vecs[10] = mkv(mkb(1, 1, 0, 8'h40, 8'h00, 1, 0, 0),      6'b000010, 6'b000010, 1, 3, 1, 3);
        vecs[11] = mkv(mkb(1, 1, 0, 8'h40, 8'h00, 0, 0, 0),      6'b010000, 6'b010010, 0, 3, 1, 3);
        vecs[12] = mkv(mkb(0, 1, 0, 8'h40, 8'h00, 0, 0, 0),      6'b000101, 6'b010111, 0, 3, 1, 3);
        vecs[13] = mkv(mkb(0, 0, 0, 8'h40, 8'h00, 0, 1, 0),      6'b001000, 6'b011111, 0, 3, 1, 3);
        vecs[14] = mkv(mkb(0, 0, 0, 8'h40, 8'h00, 0, 0, 1),      6'b000000, 6'b000000, 0, 0, 0, 0);
        vecs[15] = mkv(mkb(0, 1, 0, 8'h40, 8'h00, 0, 0, 1),      6'b000011, 6'b000011, 0, 0, 0, 0);
        vecs[16] = mkv(mkb(1, 1, 0, 8'h40, 8'h00, 1, 0, 1),      6'b000000, 6'b000000, 1, 1, 0, 0);
        vecs[17] = mkv(idle_b,                                   6'b000000, 6'b000000, 0, 1, 0, 0);

        // reset
        prst = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; prdata = '0;
        pready = 0; pslverr = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_val("reset_pulse", 64'(viol_pulse), 64'h0);
        check_val("reset_sticky", 64'(viol_sticky), 64'h0);
        check_val("reset_done", 64'(xfer_done), 64'h0);
        check_val("reset_xfer", 64'(xfer_cnt), 64'h0);
        check_val("reset_err", 64'(err_cnt), 64'h0);
        check_val("reset_maxw", 64'(max_wait_seen), 64'h0);
        prst = 1'b1;

        // directed vector table
        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].b);
            check_val($sformatf("vec%0d_pulse", i), 64'(viol_pulse), 64'(vecs[i].pulse));
            check_val($sformatf("vec%0d_sticky", i), 64'(viol_sticky), 64'(vecs[i].sticky));
            check_val($sformatf("vec%0d_done", i), 64'(xfer_done), 64'(vecs[i].done));
            check_val($sformatf("vec%0d_xfer", i), 64'(xfer_cnt), 64'(vecs[i].xfer));
            check_val($sformatf("vec%0d_err", i), 64'(err_cnt), 64'(vecs[i].err));
            check_val($sformatf("vec%0d_maxw", i), 64'(max_wait_seen), 64'(vecs[i].maxw));
        end

        // timeout after MAX_WAIT wait cycles, reported once; wait count keeps running
        apply(mkb(0, 0, 0, 8'h00, 8'h00, 0, 0, 1));
        check_val("to_clr_xfer", 64'(xfer_cnt), 64'h0);
        apply(mkb(1, 0, 1, 8'h10, 8'h55, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            apply(mkb(1, 1, 1, 8'h10, 8'h55, 0, 0, 0));
            check_val($sformatf("to_wait%0d_pulse", k), 64'(viol_pulse),
                      (k == 5) ? 64'h20 : 64'h0);
        end
        check_val("to_sticky", 64'(viol_sticky), 64'h20);
        apply(mkb(1, 1, 1, 8'h10, 8'h55, 1, 0, 0));
        check_val("to_done", 64'(xfer_done), 64'h1);
        check_val("to_maxw", 64'(max_wait_seen), 64'd10);
        check_val("to_end_pulse", 64'(viol_pulse), 64'h0);
        apply(idle_b);

        // address instability during wait states
        apply(mkb(1, 0, 0, 8'h10, 8'h00, 0, 0, 0));
        apply(mkb(1, 1, 0, 8'h10, 8'h00, 0, 0, 0));
        check_val("chg_w1", 64'(viol_pulse), 64'h0);
        apply(mkb(1, 1, 0, 8'h11, 8'h00, 0, 0, 0));
        check_val("chg_w2", 64'(viol_pulse), 64'h04);
        apply(mkb(1, 1, 0, 8'h11, 8'h00, 0, 0, 0));
        check_val("chg_w3", 64'(viol_pulse), 64'h0);
        apply(mkb(1, 1, 0, 8'h12, 8'h00, 0, 0, 0));
        check_val("chg_w4", 64'(viol_pulse), 64'h04);
        apply(mkb(1, 1, 0, 8'h12, 8'h00, 1, 0, 0));
        check_val("chg_end_pulse", 64'(viol_pulse), 64'h0);
        check_val("chg_end_done", 64'(xfer_done), 64'h1);
        check_val("chg_end_maxw", 64'(max_wait_seen), 64'd10);
        apply(idle_b);

        // randomized, mostly protocol-shaped traffic against the model
        last = idle_b;
        for (int i = 0; i < 2000; i++) begin
            legal_pen = (last.psel && !last.penable) || (last.psel && last.penable && !last.pready);
            cur = last;
            cur.psel    = legal_pen ? 1'b1 : ($urandom_range(0, 3) != 0);
            cur.penable = legal_pen;
            if ($urandom_range(0, 15) == 0) cur.penable = !cur.penable;
            if ($urandom_range(0, 31) == 0) cur.psel = !cur.psel;
            if (!legal_pen || $urandom_range(0, 15) == 0) begin
                cur.paddr  = 8'($urandom_range(0, 3));
                cur.pwdata = 8'($urandom_range(0, 3));
                cur.pwrite = 1'($urandom_range(0, 1));
            end
            cur.pready  = ($urandom_range(0, 2) == 0);
            cur.pslverr = ($urandom_range(0, 7) == 0);
            cur.clr     = ($urandom_range(0, 63) == 0);
            apply(cur);
            check_val($sformatf("rand%0d", i), dut_bundle(), model_bundle());
            last = cur;
        end

        // saturation: more completions than the counters can hold
        burst_b = mkb(1, 1, 1, 8'h77, 8'h88, 1, 1, 0);
        for (int i = 0; i < 65540; i++) begin
            apply(burst_b);
        end
        check_val("sat_xfer", 64'(xfer_cnt), 64'hFFFF);
        check_val("sat_err", 64'(err_cnt), 64'hFFFF);
        check_val("sat_model", dut_bundle(), model_bundle());

        // asynchronous reset in the middle of an ACCESS cycle
        #1;
        prst = 1'b0;
        model_reset();
        #1;
        check_val("rst_async", dut_bundle(), 64'h0);
        #1;
        prst = 1'b1;
        apply(burst_b);
        check_val("post_rst_pulse", 64'(viol_pulse), 64'h02);
        check_val("post_rst_xfer", 64'(xfer_cnt), 64'h1);
        check_val("post_rst_model", dut_bundle(), model_bundle());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
